axis_complex_frame_reader: RTL
==============================

# axis_complex_frame_reader

Streams one frame of complex accumulated sums out of a dual-port BRAM as AXI4-Stream and scales each sum down to output width. It is the read side of the complex averaging path: the accumulator writes wide signed {imag, real} sums into the BRAM, and this block reads them back in address order. It divides each half by 2^log_count, narrows it to AXIS width and marks the frame end with tlast. Typical consumers are the DMA/FFT chain and the PS-facing FIFO.

## Interface
- AXIS_TDATA_WIDTH, 32: output word width; {imag, real}, each half signed AXIS_TDATA_WIDTH/2.
- BRAM_DATA_WIDTH, 64: BRAM word width; {imag, real}, each half signed BRAM_DATA_WIDTH/2.
- BRAM_ADDR_WIDTH, 32: width of bram_porta_addr.
- FRAME_ADDR_WIDTH, 10: frame length is 2^FRAME_ADDR_WIDTH words; upper address bits are driven 0.
- aclk  in  1  sole clock; every register is on the rising edge.
- areset  in  1  synchronous, active-high reset.
- log_count  in  5  right-shift amount, latched at every frame start.
- start  in  1  level; sampled only in IDLE and starts a frame.
- continuous  in  1  sampled at each frame's last read issue; 1 = chain the next frame.
- busy  out  1  high in RUN and DRAIN.
- M_AXIS_tready  in  1  downstream ready.
- M_AXIS_tdata  out  AXIS_TDATA_WIDTH  scaled {imag, real}.
- M_AXIS_tvalid  out  1  output register holds a word.
- M_AXIS_tlast  out  1  word comes from address 2^FRAME_ADDR_WIDTH−1.
- bram_porta_clk  out  1  equals aclk.
- bram_porta_addr  out  BRAM_ADDR_WIDTH  read address.
- bram_porta_en  out  1  read strobe; data arrives on the next cycle.
- bram_porta_rddata  in  BRAM_DATA_WIDTH  read data.

## Operation
- States:
  - IDLE → RUN when start=1.
  - RUN → RUN at frame end when continuous=1; the address wraps to 0.
  - RUN → DRAIN at frame end when continuous=0.
  - DRAIN → IDLE when nothing is held and nothing is in flight.
- start is ignored outside IDLE.
- Read address counter: starts at 0 and increments on each issued read (bram_porta_en=1). Frame end is the cycle that issues address 2^FRAME_ADDR_WIDTH−1.
- Storage: output register plus one skid entry, so at most 2 words are held.
- Read issue rule: issue only in RUN, and only when held + in_flight − pop < 2, where pop = tvalid && tready.
- Capture: the in-flight word enters the output register if it is empty or popping this cycle; otherwise it enters the skid entry. The skid entry refills the output register before new data.
- tlast is carried with each word through the pipeline.
- Arithmetic, per half:
  - sign-interpret BRAM_DATA_WIDTH/2 bits;
  - arithmetic right shift by the latched log_count;
  - keep the low AXIS_TDATA_WIDTH/2 bits.
  - Scaling happens at capture time (registered), never on the output path.
- log_count changes mid-frame take effect at the next frame start.
- continuous dropped mid-frame: the current frame completes, then DRAIN.
- Reset values: tvalid=0, tlast=0, tdata=0, busy=0, bram_porta_en=0, address=0, state=IDLE, skid empty.
- Reset mid-operation: the in-flight read is discarded and all outputs take their reset values in the cycle after areset is sampled.

## Timing
- Latency with start sampled high in IDLE at edge 0:
  - cycle 1: RUN, en=1, addr=0;
  - cycle 2: rddata valid;
  - cycle 3: tvalid=1 carrying word 0.
- With tready held 1 the block sustains one word per cycle, including across continuous frame boundaries (no bubble).
- AXIS rules: tdata, tlast and tvalid are stable while tvalid && !tready, and tvalid never drops without a pop.
- busy falls in the cycle after the pop of the final tlast word.

## Configuration
- AXIS_COMPLEX_FRAME_READER_SATURATE_EN:
  - Defined: after the shift, each half is clamped to [−2^(AXIS_TDATA_WIDTH/2−1), 2^(AXIS_TDATA_WIDTH/2−1)−1] instead of truncated.
  - Undefined: plain low-bit truncation, with wrap on overflow.
- Latency and throughput are identical in both builds.

## Structure
- Package axis_complex_frame_reader_pkg holds:
  - the state encoding (IDLE, RUN, DRAIN);
  - the half-width localparam helpers;
  - the scale function, containing both the truncate and saturate variants.
- Sub-module axis_complex_skid_buffer: 2-entry output register plus skid entry with a held-count output. The top-level block owns the address/FSM logic and the credit check.

## Test plan
- Single frame: FRAME_ADDR_WIDTH=3, log_count=2, BRAM word i = {−4i, 4i}, tready=1 → first tvalid in cycle 3; 8 consecutive beats {−i, i}; tlast only on beat 8; busy low in the cycle after beat 8.
- Backpressure: tready pattern 1,0,1,0 followed by a 5-cycle low stall → exactly 8 beats, in order, no duplicates; tdata stable during the stall; held + in_flight never exceeds 2.
- Continuous: continuous=1, dropped during frame 3 → 24 gap-free beats with tready=1; tlast on beats 8, 16, 24; then IDLE.
- Narrowing, log_count=0:
  - real=65536 → 0x0000 without the macro, 0x7FFF with it;
  - real=−65537 → 0xFFFF without the macro, 0x8000 with it.
- Reset mid-frame: after 3 beats, hold tready=0 and assert areset → tvalid, busy and en are 0 in the next cycle; a new start yields word 0 first.
- start and log_count changes while busy: start is ignored; a log_count change mid-frame applies only from the next chained frame.

Source files
------------

// File: rtl/axis_complex_frame_reader_pkg.sv
// Shared state encoding, width helpers and per-half scaling for the complex frame reader.
package axis_complex_frame_reader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // Working width for scaling; wide enough for any sign-extended BRAM half.
    localparam int SCALE_W = 128;

    function automatic int half_width(input int w);
        return w / 2;
    endfunction

    // Arithmetic right shift, then optional clamp to a signed out_w range.
    // The caller keeps the low out_w bits, which gives plain wrap when saturate is 0.
    function automatic logic [SCALE_W-1:0] scale_half(
        input logic signed [SCALE_W-1:0] value,
        input logic [4:0]                shift,
        input int                        out_w,
        input logic                      saturate
    );
        logic signed [SCALE_W-1:0] shifted;
        logic signed [SCALE_W-1:0] one;
        logic signed [SCALE_W-1:0] max_v;
        logic signed [SCALE_W-1:0] min_v;
        one     = {{(SCALE_W-1){1'b0}}, 1'b1};
        shifted = value >>> shift;
        max_v   = (one <<< (out_w - 1)) - one;
        min_v   = -(one <<< (out_w - 1));
        if (saturate && (shifted > max_v)) begin
            shifted = max_v;
        end else if (saturate && (shifted < min_v)) begin
            shifted = min_v;
        end
        return shifted;
    endfunction

endpackage

// File: rtl/axis_complex_skid_buffer.sv
// Output register plus one skid entry; reports how many words it currently holds.
module axis_complex_skid_buffer
    import axis_complex_frame_reader_pkg::*;
#(
    parameter int WIDTH = 33
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       held
);

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             skid_valid_q, skid_valid_d;
    logic [WIDTH-1:0] skid_data_q, skid_data_d;
    logic             pop;

    assign pop = out_valid_q & out_ready;

    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        if (!out_valid_q || pop) begin
            // A waiting skid word always goes out ahead of the arriving word.
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_data_d   = skid_data_q;
                skid_valid_d = in_valid;
                if (in_valid) begin
                    skid_data_d = in_data;
                end
            end else if (in_valid) begin
                out_valid_d = 1'b1;
                out_data_d  = in_data;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (in_valid) begin
            skid_valid_d = 1'b1;
            skid_data_d  = in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign held      = {1'b0, out_valid_q} + {1'b0, skid_valid_q};

endmodule

// File: rtl/axis_complex_frame_reader.sv
// Reads one frame of wide {imag, real} sums from BRAM, scales each half by 2^-log_count and streams it out.
// Define AXIS_COMPLEX_FRAME_READER_SATURATE_EN to clamp each narrowed half instead of wrapping it.
module axis_complex_frame_reader
    import axis_complex_frame_reader_pkg::*;
#(
    parameter int AXIS_TDATA_WIDTH = 32,
    parameter int BRAM_DATA_WIDTH  = 64,
    parameter int BRAM_ADDR_WIDTH  = 32,
    parameter int FRAME_ADDR_WIDTH = 10
) (
    input  logic                        aclk,
    input  logic                        areset,
    input  logic [4:0]                  log_count,
    input  logic                        start,
    input  logic                        continuous,
    output logic                        busy,
    input  logic                        M_AXIS_tready,
    output logic [AXIS_TDATA_WIDTH-1:0] M_AXIS_tdata,
    output logic                        M_AXIS_tvalid,
    output logic                        M_AXIS_tlast,
    output logic                        bram_porta_clk,
    output logic [BRAM_ADDR_WIDTH-1:0]  bram_porta_addr,
    output logic                        bram_porta_en,
    input  logic [BRAM_DATA_WIDTH-1:0]  bram_porta_rddata
);

    localparam int AH = half_width(AXIS_TDATA_WIDTH);
    localparam int BH = half_width(BRAM_DATA_WIDTH);
    localparam int SW = AXIS_TDATA_WIDTH + 1;
`ifdef AXIS_COMPLEX_FRAME_READER_SATURATE_EN
    localparam logic SAT_EN = 1'b1;
`else
    localparam logic SAT_EN = 1'b0;
`endif

    state_t                      state_q, state_d;
    logic [FRAME_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [4:0]                  frame_shift_q, frame_shift_d;
    logic [4:0]                  rd_shift_q, rd_shift_d;
    logic                        rd_valid_q, rd_valid_d;
    logic                        rd_last_q, rd_last_d;

    logic                        issue;
    logic                        frame_end;
    logic                        pop;
    logic [1:0]                  held;
    logic [2:0]                  committed;
    logic signed [SCALE_W-1:0]   re_ext, im_ext;
    logic [AH-1:0]               cap_re, cap_im;
    logic [SW-1:0]               skid_out;

    // Words that will still be in the block after this edge, not counting a read issued now.
    assign pop       = M_AXIS_tvalid & M_AXIS_tready;
    assign committed = {1'b0, held} + {2'b0, rd_valid_q} - {2'b0, pop};
    assign issue     = (state_q == ST_RUN) && (committed < 3'd2);
    assign frame_end = issue && (addr_q == {FRAME_ADDR_WIDTH{1'b1}});

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        frame_shift_d = frame_shift_q;
        rd_valid_d    = issue;
        rd_last_d     = frame_end;
        rd_shift_d    = frame_shift_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d       = ST_RUN;
                    addr_d        = '0;
                    frame_shift_d = log_count;
                end
            end
            ST_RUN: begin
                if (issue) begin
                    addr_d = addr_q + 1'b1;
                end
                if (frame_end) begin
                    if (continuous) begin
                        frame_shift_d = log_count;
                    end else begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (committed == 3'd0) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q       <= ST_IDLE;
            addr_q        <= '0;
            frame_shift_q <= '0;
            rd_shift_q    <= '0;
            rd_valid_q    <= 1'b0;
            rd_last_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            frame_shift_q <= frame_shift_d;
            rd_shift_q    <= rd_shift_d;
            rd_valid_q    <= rd_valid_d;
            rd_last_q     <= rd_last_d;
        end
    end

    // Each read carries the shift of the frame it belongs to, so chained frames scale independently.
    always_comb begin
        re_ext = {{(SCALE_W-BH){bram_porta_rddata[BH-1]}}, bram_porta_rddata[BH-1:0]};
        im_ext = {{(SCALE_W-BH){bram_porta_rddata[BRAM_DATA_WIDTH-1]}},
                  bram_porta_rddata[BRAM_DATA_WIDTH-1:BH]};
        cap_re = AH'(scale_half(re_ext, rd_shift_q, AH, SAT_EN));
        cap_im = AH'(scale_half(im_ext, rd_shift_q, AH, SAT_EN));
    end

    axis_complex_skid_buffer #(
        .WIDTH (SW)
    ) u_skid (
        .clk       (aclk),
        .srst      (areset),
        .in_valid  (rd_valid_q),
        .in_data   ({rd_last_q, cap_im, cap_re}),
        .out_ready (M_AXIS_tready),
        .out_valid (M_AXIS_tvalid),
        .out_data  (skid_out),
        .held      (held)
    );

    assign M_AXIS_tlast    = skid_out[SW-1];
    assign M_AXIS_tdata    = skid_out[SW-2:0];
    assign busy            = (state_q != ST_IDLE);
    assign bram_porta_clk  = aclk;
    assign bram_porta_en   = issue;
    assign bram_porta_addr = BRAM_ADDR_WIDTH'(addr_q);

endmodule
